// File: rtl/map_tile_renderer_if.sv
// Synchronous read port into the 64x48 tile map RAM: the renderer drives the
// tile address and the RAM answers with the tile code one clock later.
interface map_tile_renderer_if;
  logic [11:0] map_rd_addr;
  logic [2:0]  map_rd_data;

  modport master (output map_rd_addr, input map_rd_data);
  modport slave  (input map_rd_addr, output map_rd_data);
endinterface

// File: rtl/map_tile_renderer.sv
// VGA stage that replaces the pixel colour with the tile under the beam during
// GAME mode, with blinking player heads; timing is delayed by a fixed 3 clocks.
module map_tile_renderer #(
  parameter int TILE_SHIFT   = 4,
  parameter int BLINK_FRAMES = 15,
  parameter int HOR_PIX      = 1024,
  parameter int VER_PIX      = 768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                i_hcount,
  input  logic [10:0]                i_vcount,
  input  logic                       i_hsync,
  input  logic                       i_vsync,
  input  logic                       i_hblnk,
  input  logic                       i_vblnk,
  input  logic [11:0]                i_rgb,
  input  logic [2:0]                 i_mode,
  input  logic [7:0]                 i_head1_x,
  input  logic [7:0]                 i_head1_y,
  input  logic [7:0]                 i_head2_x,
  input  logic [7:0]                 i_head2_y,
  map_tile_renderer_if.master        map_if,
  output logic [10:0]                o_hcount,
  output logic [10:0]                o_vcount,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_hblnk,
  output logic                       o_vblnk,
  output logic [11:0]                o_rgb
);

  typedef enum logic [2:0] {
    MODE_START       = 3'd0,
    MODE_GAME        = 3'd1,
    MODE_PLAYER1_WIN = 3'd2,
    MODE_PLAYER2_WIN = 3'd3,
    MODE_GAME_OVER   = 3'd4
  } game_mode_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          r_vsyncPrev;
  logic [CW-1:0] r_frameCnt;
  logic          r_blink;
  game_mode_e    r_mode;
  logic [7:0]    r_head1X, r_head1Y, r_head2X, r_head2Y;
  logic          w_vsRise;

  assign w_vsRise = i_vsync & ~r_vsyncPrev;

  // Frame-scoped state only moves on the vsync rising edge, so a whole frame
  // renders with one consistent mode, head set and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsyncPrev <= 1'b0;
      r_frameCnt  <= '0;
      r_blink     <= 1'b0;
      r_mode      <= MODE_START;
      r_head1X    <= '0;
      r_head1Y    <= '0;
      r_head2X    <= '0;
      r_head2Y    <= '0;
    end else begin
      r_vsyncPrev <= i_vsync;
      if (w_vsRise) begin
        r_mode   <= game_mode_e'(i_mode);
        r_head1X <= i_head1_x;
        r_head1Y <= i_head1_y;
        r_head2X <= i_head2_x;
        r_head2Y <= i_head2_y;
        if (r_frameCnt == CW'(BLINK_FRAMES - 1)) begin
          r_frameCnt <= '0;
          r_blink    <= ~r_blink;
        end else begin
          r_frameCnt <= r_frameCnt + CW'(1);
        end
      end
    end
  end

  function automatic logic headHit(input logic [7:0] hx, input logic [7:0] hy,
                                   input logic [5:0] tx, input logic [5:0] ty);
    return (hx < 8'd64) && (hy < 8'd48) &&
           (hx == {2'b00, tx}) && (hy == {2'b00, ty});
  endfunction

  logic [5:0] w_tileX, w_tileY;
  logic       w_onMap, w_highlight, w_game;

  assign w_tileX     = i_hcount[TILE_SHIFT +: 6];
  assign w_tileY     = i_vcount[TILE_SHIFT +: 6];
  assign w_onMap     = (i_hcount < 11'(HOR_PIX)) && (i_vcount < 11'(VER_PIX)) &&
                       !i_hblnk && !i_vblnk;
  assign w_highlight = r_blink && (headHit(r_head1X, r_head1Y, w_tileX, w_tileY) ||
                                   headHit(r_head2X, r_head2Y, w_tileX, w_tileY));
  assign w_game      = (r_mode == MODE_GAME);

  timing_t    r_tim0, r_tim1, r_tim2;
  logic [11:0] r_rgb0, r_rgb1, r_rgbOut;
  logic       r_onMap0, r_onMap1, r_game0, r_game1, r_hl0, r_hl1;
  logic [11:0] w_pixel;

  // Last stage: the RAM answer for the S0 address is valid now.
  always_comb begin
    w_pixel = 12'h000;
    if (r_onMap1) begin
      if (!r_game1) begin
        w_pixel = r_rgb1;
      end else if (r_hl1) begin
        w_pixel = 12'hfff;
      end else begin
        case (map_if.map_rd_data)
          3'd1:    w_pixel = 12'hf0f;
          3'd2:    w_pixel = 12'h0f0;
          3'd3:    w_pixel = 12'h00f;
          3'd4:    w_pixel = 12'hff0;
          default: w_pixel = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_if.map_rd_addr <= '0;
      r_tim0   <= '0;
      r_tim1   <= '0;
      r_tim2   <= '0;
      r_rgb0   <= '0;
      r_rgb1   <= '0;
      r_rgbOut <= '0;
      r_onMap0 <= 1'b0;
      r_onMap1 <= 1'b0;
      r_game0  <= 1'b0;
      r_game1  <= 1'b0;
      r_hl0    <= 1'b0;
      r_hl1    <= 1'b0;
    end else begin
      map_if.map_rd_addr <= {w_tileY, w_tileX};
      r_tim0   <= {i_hcount, i_vcount, i_hsync, i_vsync, i_hblnk, i_vblnk};
      r_tim1   <= r_tim0;
      r_tim2   <= r_tim1;
      r_rgb0   <= i_rgb;
      r_rgb1   <= r_rgb0;
      r_rgbOut <= w_pixel;
      r_onMap0 <= w_onMap;
      r_onMap1 <= r_onMap0;
      r_game0  <= w_game;
      r_game1  <= r_game0;
      r_hl0    <= w_highlight;
      r_hl1    <= r_hl0;
    end
  end

  assign o_hcount = r_tim2.hcount;
  assign o_vcount = r_tim2.vcount;
  assign o_hsync  = r_tim2.hsync;
  assign o_vsync  = r_tim2.vsync;
  assign o_hblnk  = r_tim2.hblnk;
  assign o_vblnk  = r_tim2.vblnk;
  assign o_rgb    = r_rgbOut;

endmodule
